// File: rtl/fetch_unit_pkg.sv
// Fetch-unit parameters, state encoding and PC helper.
package fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;
   localparam logic [3:0]  RMASK_WORD       = 4'hF;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_STALL = 2'd2
   } fetch_state_e;

   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I datapath types used across the frontend and backend.
package rv32i_types;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] pc_next;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Redirect, instruction-memory and instruction-queue signals seen by the fetch unit.
interface fetch_unit_if;
   import rv32i_types::*;

   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic        iq_enq;
   fetch_pkt_t  iq_data;
   logic        iq_full;

   modport master (
      input  redirect_valid, redirect_pc, imem_rdata, imem_resp, iq_full,
      output imem_addr, imem_rmask, iq_enq, iq_data
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_rdata, imem_resp, iq_full,
      input  imem_addr, imem_rmask, iq_enq, iq_data
   );

endinterface

// File: rtl/fetch_unit.sv
// Fetch unit: one outstanding imem read, packets pushed into the instruction queue,
// redirects squash in-flight data and restart at the new PC.
module fetch_unit
   import rv32i_types::*;
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         discard_q, discard_d;
   fetch_pkt_t   hold_q, hold_d;

   logic [31:0]  imem_addr;
   logic [3:0]   imem_rmask;
   logic         iq_enq;
   fetch_pkt_t   iq_data;
   fetch_pkt_t   pkt;

   assign pkt = '{pc: pc_q, inst: bus.imem_rdata, pc_next: pc_inc(pc_q)};

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      discard_d  = discard_q;
      hold_d     = hold_q;
      imem_addr  = pc_q;
      imem_rmask = 4'h0;
      iq_enq     = 1'b0;
      iq_data    = hold_q;

      if (rst) begin
         state_d = state_q;
      end else if (bus.redirect_valid) begin
         // Redirect wins: nothing is enqueued or requested this cycle.
         pc_d = bus.redirect_pc & ~32'h3;
         unique case (state_q)
            S_WAIT: begin
               if (bus.imem_resp) begin
                  state_d   = S_REQ;
                  discard_d = 1'b0;
               end else begin
                  discard_d = 1'b1;
               end
            end
            S_STALL: begin
               state_d = S_REQ;
               hold_d  = '0;
            end
            default: state_d = S_REQ;
         endcase
      end else begin
         unique case (state_q)
            S_REQ: begin
               imem_rmask = RMASK_WORD;
               state_d    = S_WAIT;
            end
            S_WAIT: begin
               if (bus.imem_resp) begin
                  if (discard_q) begin
                     discard_d = 1'b0;
                     state_d   = S_REQ;
                  end else if (!bus.iq_full) begin
                     // Enqueue and issue the next request back to back.
                     iq_enq     = 1'b1;
                     iq_data    = pkt;
                     pc_d       = pc_inc(pc_q);
                     imem_addr  = pc_inc(pc_q);
                     imem_rmask = RMASK_WORD;
                  end else begin
                     hold_d  = pkt;
                     state_d = S_STALL;
                  end
               end
            end
            S_STALL: begin
               if (!bus.iq_full) begin
                  iq_enq  = 1'b1;
                  pc_d    = pc_inc(pc_q);
                  state_d = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_REQ;
         pc_q      <= RESET_PC;
         discard_q <= 1'b0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         discard_q <= discard_d;
         hold_q    <= hold_d;
      end
   end

   assign bus.imem_addr  = imem_addr;
   assign bus.imem_rmask = imem_rmask;
   assign bus.iq_enq     = iq_enq;
   assign bus.iq_data    = iq_data;

endmodule
